aes_key_expansion: RTL

//  Iterative AES-128 key schedule. Sits directly upstream of Round: accepts one
//  128-bit cipher key, emits round keys 0..10 in order, one per output transfer,
//  on round_key/key_valid_out. These outputs drive Round.round_key/key_valid_in.

---
 rtl/aes_key_expansion.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: loads one cipher key and emits round keys 0..NUM_ROUNDS
// in order over a valid/ready handshake. Only the current round key is stored. Each
// accepted round key produces the next one on the same edge.
module aes_key_expansion #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              ready_out,
    output logic              key_valid_out,
    input  logic              key_ready_in,
    output logic [DATA_W-1:0] round_key,
    output logic [3:0]        round_idx,
    output logic              done
);

    localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {StIdle, StEmit} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] w_key_next;
    logic [3:0]        r_idx;
    logic [3:0]        w_idx_next;
    logic [7:0]        r_rcon;
    logic [7:0]        w_rcon_next;
    logic              r_done;
    logic              w_done_next;

    logic              w_transfer;
    logic [31:0]       w_rot;
    logic [31:0]       w_temp;
    logic [31:0]       w_n0;
    logic [31:0]       w_n1;
    logic [31:0]       w_n2;
    logic [31:0]       w_n3;
    logic [7:0]        w_rcon_xtime;

    // Byte substitution; {~a, 3'b000} is (255 - a) * 8 since entry 0 sits at the top.
    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        return SboxTable[{~a, 3'b000} +: 8];
    endfunction

    assign ready_out     = (r_state == StIdle);
    assign key_valid_out = (r_state == StEmit);
    assign round_key     = r_key;
    assign round_idx     = r_idx;
    assign done          = r_done;
    assign w_transfer    = key_valid_out && key_ready_in;

    // One word-column step: derive the next round key from the current one.
    always_comb begin
        w_rot  = {r_key[23:0], r_key[31:24]};
        w_temp = {aes_sbox(w_rot[31:24]), aes_sbox(w_rot[23:16]),
                  aes_sbox(w_rot[15:8]),  aes_sbox(w_rot[7:0])} ^ {r_rcon, 24'h000000};
        w_n0   = r_key[127:96] ^ w_temp;
        w_n1   = r_key[95:64]  ^ w_n0;
        w_n2   = r_key[63:32]  ^ w_n1;
        w_n3   = r_key[31:0]   ^ w_n2;
        w_rcon_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end

    // Next-state logic: load in idle, advance on each accepted round key.
    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_idx_next   = r_idx;
        w_rcon_next  = r_rcon;
        w_done_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (key_valid_in) begin
                    w_state_next = StEmit;
                    w_key_next   = key_in;
                    w_idx_next   = 4'd0;
                    w_rcon_next  = 8'h01;
                end
            end
            StEmit: begin
                if (w_transfer) begin
                    if (r_idx == LastIdx) begin
                        // Final key consumed; keep it visible, signal completion.
                        w_state_next = StIdle;
                        w_done_next  = 1'b1;
                    end else begin
                        w_key_next  = {w_n0, w_n1, w_n2, w_n3};
                        w_idx_next  = r_idx + 4'd1;
                        w_rcon_next = w_rcon_xtime;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State registers; reset aborts any schedule in progress immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_key   <= '0;
            r_idx   <= 4'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_idx   <= w_idx_next;
            r_rcon  <= w_rcon_next;
            r_done  <= w_done_next;
        end
    end

endmodule
